// File: rtl/life_pkg.sv
// Shared definitions for the Life sequencer: PE command encodings, FSM states
// and default board dimensions.
package life_pkg;

  localparam int N_PX_DEF    = 16;
  localparam int N_PY_DEF    = 16;
  localparam int PE_CMD_BITS = 2;

  localparam logic [PE_CMD_BITS-1:0] CMD_NOP  = 2'd0;
  localparam logic [PE_CMD_BITS-1:0] CMD_LOAD = 2'd1;
  localparam logic [PE_CMD_BITS-1:0] CMD_READ = 2'd2;
  localparam logic [PE_CMD_BITS-1:0] CMD_STEP = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_DUMP = 3'd3,
    S_FIN  = 3'd4
  } seq_state_t;

endpackage

// File: rtl/life_raster_cnt.sv
// Raster-order (x fastest, then y) address counter for the PE array.
// o_last flags cell (N_PX-1, N_PY-1); an increment there wraps to (0, 0).
module life_raster_cnt #(
  parameter  int N_PX = 16,
  parameter  int N_PY = 16,
  localparam int AXW  = (N_PX > 1) ? $clog2(N_PX) : 1,
  localparam int AYW  = (N_PY > 1) ? $clog2(N_PY) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           i_clr,
  input  logic           i_inc,
  output logic [AXW-1:0] o_x,
  output logic [AYW-1:0] o_y,
  output logic           o_last
);

  logic [AXW-1:0] r_x;
  logic [AYW-1:0] r_y;
  logic           w_x_end;
  logic           w_y_end;

  assign w_x_end = (r_x == AXW'(N_PX - 1));
  assign w_y_end = (r_y == AYW'(N_PY - 1));

  // NOTE: sequential state uses non-blocking assignments only, so every
  // always_ff sees the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_inc) begin
      if (w_x_end) begin
        r_x <= '0;
        r_y <= w_y_end ? '0 : r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  assign o_x    = r_x;
  assign o_y    = r_y;
  assign o_last = w_x_end && w_y_end;

endmodule

// File: rtl/life_seq.sv
// Job sequencer for the Life PE array: load a board from the host, step it up
// to gen_count generations (stopping on extinction), then stream it back out.
module life_seq
  import life_pkg::*;
#(
  parameter  int N_PX       = N_PX_DEF,
  parameter  int N_PY       = N_PY_DEF,
  parameter  int GEN_BITS   = 16,
  parameter  int STATE_BITS = 1,
  localparam int AXW        = (N_PX > 1) ? $clog2(N_PX) : 1,
  localparam int AYW        = (N_PY > 1) ? $clog2(N_PY) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [GEN_BITS-1:0]    gen_count,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic [STATE_BITS-1:0]  ld_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [STATE_BITS-1:0]  out_data,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done,
  output logic                   extinct,
  output logic [GEN_BITS-1:0]    gens_run,
  output logic [PE_CMD_BITS-1:0] cmd,
  output logic [STATE_BITS-1:0]  state_in,
  output logic [AXW-1:0]         adr_x,
  output logic [AYW-1:0]         adr_y,
  input  logic [STATE_BITS-1:0]  state_out,
  input  logic                   active
);

  seq_state_t              r_state, w_next;
  logic [GEN_BITS-1:0]     r_remaining, r_gens_run;
  logic                    r_extinct, r_rd_done;
  logic                    r_out_valid, r_out_last;
  logic [STATE_BITS-1:0]   r_out_data;

  logic                    w_clr, w_inc, w_last;
  logic                    w_accept, w_step, w_set_extinct, w_rd_fire;
  logic [PE_CMD_BITS-1:0]  w_cmd;
  logic [STATE_BITS-1:0]   w_state_in;

  life_raster_cnt #(.N_PX(N_PX), .N_PY(N_PY)) u_raster (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_clr),
    .i_inc  (w_inc),
    .o_x    (adr_x),
    .o_y    (adr_y),
    .o_last (w_last)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    w_next        = r_state;
    w_cmd         = CMD_NOP;
    w_state_in    = '0;
    w_clr         = 1'b0;
    w_inc         = 1'b0;
    w_accept      = 1'b0;
    w_step        = 1'b0;
    w_set_extinct = 1'b0;
    w_rd_fire     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_clr    = 1'b1;
          w_next   = S_LOAD;
        end
      end
      S_LOAD: begin
        if (ld_valid) begin
          w_cmd      = CMD_LOAD;
          w_state_in = ld_data;
          w_inc      = 1'b1;
          if (w_last) w_next = S_RUN;
        end
      end
      S_RUN: begin
        if (r_remaining == '0) begin
          w_next = S_DUMP;
        end else if (!active) begin
          w_set_extinct = 1'b1;
          w_next        = S_DUMP;
        end else begin
          w_cmd  = CMD_STEP;
          w_step = 1'b1;
        end
      end
      S_DUMP: begin
        // Refill the output register when it is empty or being drained now.
        if ((!r_out_valid || out_ready) && !r_rd_done) begin
          w_cmd     = CMD_READ;
          w_rd_fire = 1'b1;
          w_inc     = 1'b1;
        end
        if (r_out_valid && out_ready && r_out_last) w_next = S_FIN;
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_gens_run  <= '0;
      r_extinct   <= 1'b0;
      r_rd_done   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_remaining <= gen_count;
        r_gens_run  <= '0;
        r_extinct   <= 1'b0;
        r_rd_done   <= 1'b0;
      end
      if (w_step) begin
        r_remaining <= r_remaining - 1'b1;
        r_gens_run  <= r_gens_run + 1'b1;
      end
      if (w_set_extinct) r_extinct <= 1'b1;
      if (w_rd_fire) begin
        r_out_valid <= 1'b1;
        r_out_data  <= state_out;
        r_out_last  <= w_last;
        if (w_last) r_rd_done <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end

  assign ld_ready  = (r_state == S_LOAD);
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_FIN);
  assign extinct   = r_extinct;
  assign gens_run  = r_gens_run;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign cmd       = w_cmd;
  assign state_in  = w_state_in;

endmodule

// File: tb/tb_life_seq.sv
// Bench for life_seq: a behavioural 16x16 Life array answers the sequencer's
// commands; expected dump cells are queued at load time and popped per beat.
module tb_life_seq;
  import life_pkg::*;

  localparam int NX = 16;
  localparam int NY = 16;
  localparam int NC = NX * NY;

  typedef logic [NC-1:0] board_t;

  logic        clk = 1'b0;
  logic        reset, start, ld_valid, out_ready, active;
  logic [15:0] gen_count;
  logic [0:0]  ld_data, out_data, state_in, state_out;
  logic        ld_ready, out_valid, out_last, busy, done, extinct;
  logic [15:0] gens_run;
  logic [1:0]  cmd;
  logic [3:0]  adr_x, adr_y;

  int     checks = 0;
  int     errors = 0;
  int     step_cnt = 0;
  int     done_cnt = 0;
  board_t grid = '0;
  board_t ref_glider_dump;
  logic   sb_q[$];

  always #5 clk = ~clk;

  life_seq dut (
    .clk(clk), .reset(reset), .start(start), .gen_count(gen_count),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done), .extinct(extinct),
    .gens_run(gens_run), .cmd(cmd), .state_in(state_in), .adr_x(adr_x),
    .adr_y(adr_y), .state_out(state_out), .active(active)
  );

  // Behavioural PE array: dead cells beyond the border.
  function automatic board_t life_step(input board_t b);
    board_t n = '0;
    for (int y = 0; y < NY; y++)
      for (int x = 0; x < NX; x++) begin
        int cnt = 0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            if ((dx != 0 || dy != 0) && x + dx >= 0 && x + dx < NX && y + dy >= 0 && y + dy < NY)
              cnt += int'(b[(y + dy) * NX + x + dx]);
        n[y * NX + x] = b[y * NX + x] ? (cnt == 2 || cnt == 3) : (cnt == 3);
      end
    return n;
  endfunction

  assign state_out = grid[int'(adr_y) * NX + int'(adr_x)];
  assign active    = |grid;

  always @(posedge clk) begin
    if (cmd == CMD_LOAD)      grid[int'(adr_y) * NX + int'(adr_x)] <= state_in[0];
    else if (cmd == CMD_STEP) grid <= life_step(grid);
    if (cmd == CMD_STEP) step_cnt <= step_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  function automatic board_t glider_at(input int ox, input int oy);
    board_t b = '0;
    b[(oy + 0) * NX + ox + 1] = 1'b1;
    b[(oy + 1) * NX + ox + 2] = 1'b1;
    b[(oy + 2) * NX + ox + 0] = 1'b1;
    b[(oy + 2) * NX + ox + 1] = 1'b1;
    b[(oy + 2) * NX + ox + 2] = 1'b1;
    return b;
  endfunction

  task automatic start_job(input int gens);
    start     = 1'b1;
    gen_count = 16'(gens);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_load(input board_t init, input bit stall, input bit poke);
    int  idx = 0;
    int  cyc = 0;
    bit  hs;
    while (idx < NC && cyc < 5000) begin
      ld_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      ld_data  = init[idx];
      if (poke) begin
        start     = 1'b1;
        gen_count = 16'd50;
      end
      hs = ld_valid && (ld_ready === 1'b1);
      @(negedge clk);
      cyc++;
      if (hs) idx++;
    end
    ld_valid = 1'b0;
    start    = 1'b0;
    checks++;
    if (idx != NC) begin
      errors++;
      $display("FAIL load_timeout: beats %0d required %0d", idx, NC);
    end
  endtask

  task automatic do_dump(input bit stall, input int stop_after, output board_t got);
    int   beat = 0;
    int   cyc = 0;
    bit   held = 1'b0;
    logic pd = 1'b0, pl = 1'b0;
    logic exp_v;
    got = '0;
    while (beat < stop_after && cyc < 5000) begin
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (held) begin
        checks++;
        if (out_valid !== 1'b1 || out_data[0] !== pd || out_last !== pl) begin
          errors++;
          $display("FAIL stall_hold beat %0d: valid %b data %b last %b required 1 %b %b",
                   beat, out_valid, out_data, out_last, pd, pl);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        exp_v = (sb_q.size() > 0) ? sb_q.pop_front() : 1'bx;
        checks++;
        if (out_data[0] !== exp_v) begin
          errors++;
          $display("FAIL dump_data beat %0d (x=%0d y=%0d): got %b required %b",
                   beat, beat % NX, beat / NX, out_data, exp_v);
        end
        checks++;
        if (out_last !== (beat == NC - 1)) begin
          errors++;
          $display("FAIL out_last beat %0d: got %b required %b", beat, out_last, beat == NC - 1);
        end
        got[beat] = out_data[0];
        beat++;
        held = 1'b0;
      end else begin
        held = (out_valid === 1'b1);
        pd   = out_data[0];
        pl   = out_last;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    checks++;
    if (beat != stop_after) begin
      errors++;
      $display("FAIL dump_timeout: beats %0d required %0d", beat, stop_after);
    end
  endtask

  task automatic run_job(input string tag, input board_t init, input int gens,
                         input board_t exp_b, input bit stall, input bit poke,
                         input int exp_gens, input bit exp_ext, output board_t got);
    int d0 = done_cnt;
    int s0 = step_cnt;
    int cyc = 0;
    for (int i = 0; i < NC; i++) sb_q.push_back(exp_b[i]);
    start_job(gens);
    do_load(init, stall, poke);
    do_dump(stall, NC, got);
    while (busy !== 1'b0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_return: busy %b required 0", tag, busy);
    end
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL %s done_pulses: got %0d required 1", tag, done_cnt - d0);
    end
    checks++;
    if (gens_run !== 16'(exp_gens)) begin
      errors++;
      $display("FAIL %s gens_run: got %0d required %0d", tag, gens_run, exp_gens);
    end
    checks++;
    if (step_cnt - s0 != exp_gens) begin
      errors++;
      $display("FAIL %s step_cmds: got %0d required %0d", tag, step_cnt - s0, exp_gens);
    end
    checks++;
    if (extinct !== exp_ext) begin
      errors++;
      $display("FAIL %s extinct: got %b required %b", tag, extinct, exp_ext);
    end
    sb_q.delete();
  endtask

  task automatic test_reset();
    logic [63:0] snap;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    snap = 64'({busy, ld_ready, out_valid, out_last, done, extinct, cmd, adr_x, adr_y, state_in, gens_run});
    checks++;
    if (snap !== 64'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0", snap);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || cmd !== CMD_NOP) begin
      errors++;
      $display("FAIL reset_idle_hold: busy %b cmd %0d required 0 0", busy, cmd);
    end
  endtask

  task automatic test_blinker();
    board_t init = '0, exp_b = '0, got;
    init[4 * NX + 5] = 1'b1; init[5 * NX + 5] = 1'b1; init[6 * NX + 5] = 1'b1;
    exp_b[5 * NX + 4] = 1'b1; exp_b[5 * NX + 5] = 1'b1; exp_b[5 * NX + 6] = 1'b1;
    run_job("blinker", init, 1, exp_b, 1'b0, 1'b0, 1, 1'b0, got);
  endtask

  task automatic test_glider();
    run_job("glider", glider_at(3, 3), 4, glider_at(4, 4), 1'b0, 1'b0, 4, 1'b0, ref_glider_dump);
  endtask

  task automatic test_extinction();
    board_t init = '0, got;
    init[7 * NX + 7] = 1'b1;
    run_job("extinct", init, 10, '0, 1'b0, 1'b0, 1, 1'b1, got);
  endtask

  task automatic test_zero_gens();
    board_t got;
    run_job("zero_gens", glider_at(9, 2), 0, glider_at(9, 2), 1'b0, 1'b0, 0, 1'b0, got);
  endtask

  task automatic test_stalls();
    board_t got;
    run_job("stalls", glider_at(3, 3), 4, glider_at(4, 4), 1'b1, 1'b0, 4, 1'b0, got);
    checks++;
    if (got !== ref_glider_dump) begin
      errors++;
      $display("FAIL stall_vs_nostall: got %h required %h", got, ref_glider_dump);
    end
  endtask

  task automatic test_start_while_busy();
    board_t init = '0, got;
    init[4 * NX + 5] = 1'b1; init[5 * NX + 5] = 1'b1; init[6 * NX + 5] = 1'b1;
    run_job("start_busy", init, 2, init, 1'b0, 1'b1, 2, 1'b0, got);
  endtask

  task automatic test_reset_mid();
    board_t init = '0, got;
    logic [63:0] snap;
    init[4 * NX + 5] = 1'b1; init[5 * NX + 5] = 1'b1; init[6 * NX + 5] = 1'b1;
    start_job(1000);
    do_load(init, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (cmd !== CMD_STEP || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_run_stepping: cmd %0d busy %b required 3 1", cmd, busy);
    end
    reset = 1'b1;
    @(negedge clk);
    snap = 64'({busy, ld_ready, out_valid, out_last, done, extinct, cmd, adr_x, adr_y, state_in, gens_run});
    checks++;
    if (snap !== 64'd0) begin
      errors++;
      $display("FAIL reset_mid_run: got %h required 0", snap);
    end
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NC; i++) sb_q.push_back(init[i]);
    start_job(0);
    do_load(init, 1'b0, 1'b0);
    do_dump(1'b0, 20, got);
    reset = 1'b1;
    @(negedge clk);
    snap = 64'({busy, ld_ready, out_valid, out_last, done, extinct, cmd, adr_x, adr_y, state_in, gens_run});
    checks++;
    if (snap !== 64'd0) begin
      errors++;
      $display("FAIL reset_mid_dump: got %h required 0", snap);
    end
    reset = 1'b0;
    sb_q.delete();
    @(negedge clk);
  endtask

  task automatic test_after_reset();
    board_t got;
    run_job("after_reset", glider_at(3, 3), 4, glider_at(4, 4), 1'b0, 1'b0, 4, 1'b0, got);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    gen_count = '0;
    ld_valid  = 1'b0;
    ld_data   = '0;
    out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_blinker();
    test_glider();
    test_extinction();
    test_zero_gens();
    test_stalls();
    test_start_while_busy();
    test_reset_mid();
    test_after_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
